// File: rtl/axi_slave_ram_dp.sv
// axi_slave_ram_dp: AXI4 slave RAM with independent read/write burst engines on a dual-port array
module axi_slave_ram_dp #(
  parameter int             DW        = 128,
  parameter int             AW        = 32,
  parameter int             IDW       = 8,
  parameter int             MEM_AW    = 16,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter int             RD_LAT    = 1
) (
  input  logic              pll_core_cpuclk_i,
  input  logic              pad_cpu_rst_b_i,
  input  logic [IDW-1:0]    awid_i,
  input  logic [AW-1:0]     awaddr_i,
  input  logic [7:0]        awlen_i,
  input  logic [2:0]        awsize_i,
  input  logic [1:0]        awburst_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [DW-1:0]     wdata_i,
  input  logic [DW/8-1:0]   wstrb_i,
  input  logic              wlast_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [IDW-1:0]    bid_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  input  logic [IDW-1:0]    arid_i,
  input  logic [AW-1:0]     araddr_i,
  input  logic [7:0]        arlen_i,
  input  logic [2:0]        arsize_i,
  input  logic [1:0]        arburst_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [IDW-1:0]    rid_o,
  output logic [DW-1:0]     rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i
);
  localparam int STRB = DW / 8;
  localparam int OFF  = $clog2(STRB);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  logic [DW-1:0] mem [0:2**MEM_AW-1];

  function automatic logic wrap_ok(input logic [7:0] len);
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

  // Illegal WRAP lengths fall through to the INCR arithmetic
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                               input logic [7:0] len, input logic [1:0] bst);
    logic [AW-1:0] step, inc, span, lo;
    step = AW'(1) << sz;
    inc  = (a & ~(step - AW'(1))) + step;
    span = (AW'(len) + AW'(1)) << sz;
    lo   = a & ~(span - AW'(1));
    return (bst == 2'd0) ? a : (bst == 2'd2 && wrap_ok(len) && inc == lo + span) ? lo : inc;
  endfunction

  function automatic logic beat_err(input logic [AW-1:0] a, input logic [2:0] sz,
                                    input logic [7:0] len, input logic [1:0] bst);
    return (((a ^ BASE_ADDR) >> (MEM_AW + OFF)) != '0) || (sz > 3'(OFF)) ||
           (bst == 2'd2 && !wrap_ok(len));
  endfunction

  w_state_e          w_state_q;
  logic              awready_q, wready_q, bvalid_q, werr_q;
  logic [IDW-1:0]    bid_q;
  logic [1:0]        bresp_q, wburst_q;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [7:0]        wlen_q, wcnt_q;
  logic [2:0]        wsize_q;
  logic              w_hs, w_berr, w_err_d;
  logic [MEM_AW-1:0] w_idx;

  assign w_hs    = wvalid_i && wready_q;
  assign w_berr  = beat_err(waddr_q, wsize_q, wlen_q, wburst_q);
  assign w_err_d = werr_q || w_berr || (wlast_i != (wcnt_q == wlen_q));
  assign waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
  assign w_idx   = MEM_AW'(waddr_q >> OFF);

  // Write channel FSM: accept AW, take beats until count==len, then hold B until accepted
  always_ff @(posedge pll_core_cpuclk_i or negedge pad_cpu_rst_b_i) begin
    if (!pad_cpu_rst_b_i) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid_i && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= awid_i;
            waddr_q   <= awaddr_i;
            wlen_q    <= awlen_i;
            wsize_q   <= awsize_i;
            wburst_q  <= awburst_i;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: if (w_hs) begin
          waddr_q <= waddr_d;
          wcnt_q  <= wcnt_q + 8'd1;
          werr_q  <= w_err_d;
          if (wcnt_q == wlen_q) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_err_d ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (bready_i) begin
          bvalid_q  <= 1'b0;
          bresp_q   <= 2'b00;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Write port: strobed byte lanes, suppressed for decode/size/wrap errors
  always_ff @(posedge pll_core_cpuclk_i) begin
    if (w_hs && !w_berr)
      for (int b = 0; b < STRB; b++)
        if (wstrb_i[b]) mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
  end

  r_state_e          r_state_q;
  logic              arready_q, rvalid_q, rlast_q;
  logic [IDW-1:0]    rid_q;
  logic [DW-1:0]     rdata_q;
  logic [1:0]        rresp_q, rburst_q;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [7:0]        rlen_q, rcnt_q;
  logic [2:0]        rsize_q;
  logic [3:0]        rwait_q;
  logic              ar_hs, r_adv, r_first, r_load, l_err;
  logic [AW-1:0]     l_addr;
  logic [7:0]        l_len, l_cnt;
  logic [2:0]        l_size;
  logic [1:0]        l_burst;

  // The first beat may load straight off the AR bus when the latency is one cycle
  always_comb begin
    ar_hs   = arvalid_i && arready_q;
    r_adv   = rvalid_q && rready_i;
    r_first = r_state_q == R_IDLE;
    l_addr  = r_first ? araddr_i : raddr_q;
    l_len   = r_first ? arlen_i : rlen_q;
    l_size  = r_first ? arsize_i : rsize_q;
    l_burst = r_first ? arburst_i : rburst_q;
    l_cnt   = r_first ? 8'd0 : rcnt_q;
    r_load  = (ar_hs && RD_LAT == 1) || (r_state_q == R_WAIT && rwait_q == 4'd1) ||
              (r_state_q == R_DATA && r_adv && !rlast_q);
    l_err   = beat_err(l_addr, l_size, l_len, l_burst);
    raddr_d = next_addr(l_addr, l_size, l_len, l_burst);
  end

  // Read channel FSM: latency countdown, then registered beats with no bubble on acceptance
  always_ff @(posedge pll_core_cpuclk_i or negedge pad_cpu_rst_b_i) begin
    if (!pad_cpu_rst_b_i) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rwait_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            rid_q     <= arid_i;
            raddr_q   <= araddr_i;
            rlen_q    <= arlen_i;
            rsize_q   <= arsize_i;
            rburst_q  <= arburst_i;
            rcnt_q    <= '0;
            rwait_q   <= 4'(RD_LAT - 1);
            r_state_q <= (RD_LAT == 1) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          rwait_q <= rwait_q - 4'd1;
          if (rwait_q == 4'd1) r_state_q <= R_DATA;
        end
        R_DATA: if (r_adv && rlast_q) begin
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
          arready_q <= 1'b1;
          r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
      if (r_load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= l_err ? '0 : mem[MEM_AW'(l_addr >> OFF)];
        rresp_q  <= l_err ? 2'b10 : 2'b00;
        rlast_q  <= l_cnt == l_len;
        raddr_q  <= raddr_d;
        rcnt_q   <= l_cnt + 8'd1;
      end
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
endmodule
